// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width
// and the nibble-counter width helper.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2 of the nibble count, floored at one bit so WIDTH=4 still has a counter
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/response bundle between a requester (master) and the serial adder (slave).
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );

endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; also exposes the carry into bit 3
// so the caller can derive signed overflow on the top nibble.
module cla4_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] f,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      assign p[gi] = a[gi] | b[gi];
      assign g[gi] = a[gi] & b[gi];
      assign f[gi] = a[gi] ^ b[gi] ^ c[gi];
    end
  endgenerate

  // Every carry is a flat sum of products of g/p and cin, no rippling
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single
// cla4_slice, with the inter-nibble carry held in a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             zero_reg, zero_next;

  logic [NIBBLE_W-1:0] slice_f;
  logic                slice_cout;
  logic                slice_c3;

  cla4_slice u_slice (
    .a    (a_sh_reg[NIBBLE_W-1:0]),
    .b    (b_sh_reg[NIBBLE_W-1:0]),
    .cin  (carry_reg),
    .f    (slice_f),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      zero_reg  <= zero_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction becomes a + ~b + 1: invert b here, seed the carry with 1
          a_sh_next  = bus.a;
          b_sh_next  = bus.sub ? ~bus.b : bus.b;
          carry_next = bus.sub ? 1'b1 : bus.cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_sh_next  = a_sh_reg >> NIBBLE_W;
        b_sh_next  = b_sh_reg >> NIBBLE_W;
        sum_next   = (sum_reg >> NIBBLE_W) | (WIDTH'(slice_f) << (WIDTH - NIBBLE_W));
        carry_next = slice_cout;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(NIBBLES - 1)) begin
          cout_next  = slice_cout;
          ovf_next   = slice_c3 ^ slice_cout;
          zero_next  = (sum_next == '0);
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.zero      = zero_reg;

endmodule
